vga_fb_reader: RTL and testbench
================================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter SCALE, default 4: screen pixels per frame-buffer pixel, both axes; FB_W=H_ACTIVE/SCALE, FB_H=V_ACTIVE/SCALE.
REQ-004 SHALL have parameter DEPTH_W, default 15: RAM address width, at least clog2(FB_W*FB_H).
REQ-005 SHALL have ports: clk_i  in  1  pixel clock; all logic on rising edge.
REQ-006 rstn_i  in  1  asynchronous, active-low reset.
REQ-007 en_i  in  1  enable; when low, no RAM reads and colour forced black.
REQ-008 sof_i  in  1  one-cycle pulse coincident with first de_i cycle of a frame.
REQ-009 de_i  in  1  display-enable from timing generator.
REQ-010 hsync_i, vsync_i  in  1 each  syncs from timing generator.
REQ-011 ram_addr_o  out  DEPTH_W  read address to single-port frame-buffer RAM.
REQ-012 ram_en_o  out  1  RAM port enable; ram_we_o  out  1  tied 0.
REQ-013 ram_data_i  in  12  RAM read data, valid one cycle after ram_en_o; [11:8] R, [7:4] G, [3:0] B.
REQ-014 red_o, green_o, blue_o  out  4 each; hsync_o, vsync_o, de_o  out  1 each: aligned VGA outputs.
REQ-015 ovf_o  out  1  sticky: frame exceeded H_ACTIVE or V_ACTIVE; cleared by sof_i.

Function
REQ-016 FSM states WAIT_SOF, RUN; reset -> WAIT_SOF; WAIT_SOF -> RUN on sof_i=1 with en_i=1; RUN -> WAIT_SOF on en_i=0.
REQ-017 In WAIT_SOF: ram_en_o=0, colour outputs 0, syncs still forwarded.
REQ-018 Counters: x_sub (0..SCALE-1), x_col (0..FB_W-1), y_sub (0..SCALE-1), line_base (multiple of FB_W); no multiplier used.
REQ-019 Stage 1: ram_addr_o <= line_base + x_col and ram_en_o <= de_i when RUN (or sof_i accepted this cycle, using address 0).
REQ-020 On each de_i=1 cycle: x_sub increments; on wrap x_col increments; x_col saturating at FB_W-1 sets ovf_o.
REQ-021 On de_i falling edge: x_sub, x_col <= 0; y_sub increments; on y_sub wrap line_base += FB_W; line_base saturating at (FB_H-1)*FB_W sets ovf_o.
REQ-022 sof_i=1: x_sub, y_sub, x_col, line_base <= 0, ovf_o <= 0, before the cycle's address is formed; sof_i takes priority over all other counter updates.
REQ-023 Stage 2: colour outputs <= ram_data_i fields when delayed ram_en_o=1, else 0.
REQ-024 de_i, hsync_i, vsync_i SHALL be delayed exactly 2 cycles to de_o, hsync_o, vsync_o in every state.
REQ-025 Latency de_i to first valid colour: exactly 2 cycles; one RAM read per de_i cycle, no gaps.
REQ-026 Colour outputs SHALL be 0 whenever de_o=0.

Reset
REQ-027 rstn_i=0 asynchronously: state WAIT_SOF, all counters 0, ram_addr_o=0, ram_en_o=0, colours 0, de_o=0, hsync_o=1, vsync_o=1, ovf_o=0.
REQ-028 Reset mid-frame SHALL discard in-flight pipeline data; after release no RAM read before next sof_i.

Structure
REQ-029 Shared package vga_pkg SHALL hold H_ACTIVE, V_ACTIVE, SCALE defaults, pixel field widths, and the FSM state typedef.
REQ-030 Sub-module vga_fb_addr_gen SHALL contain the counters and FSM; top level holds the 2-stage pipeline.

Verification
REQ-031 Full frame, RAM preloaded mem[a]=a[11:0]: screen pixel (x=5,y=9) -> address 2*160+1=321, rgb=0x141 two cycles after its de_i.
REQ-032 Line start: 4 de_i cycles -> ram_addr_o 0,0,0,0 then 1; line 4 first pixel -> address 160.
REQ-033 en_i=0 for whole frame -> ram_en_o never 1, colours 0, hsync_o/vsync_o equal inputs delayed 2 cycles.
REQ-034 700 de_i cycles in one line -> x_col holds 159 from cycle 640, ovf_o=1; next sof_i clears ovf_o.
REQ-035 rstn_i low at line 200 -> outputs at reset values within same cycle; no ram_en_o until next sof_i; next frame address 0 first.
REQ-036 sof_i in same cycle as de_i falling of stale line -> counters 0, ram_addr_o=0 next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults, pixel field widths and FSM state encoding for the frame-buffer reader
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int SCALE_DEF    = 4;
  localparam int DEPTH_W_DEF  = 15;

  localparam int CH_W  = 4;
  localparam int RGB_W = 3 * CH_W;

  typedef logic [0:0] fb_state_t;
  localparam fb_state_t ST_WAIT_SOF = 1'b0;
  localparam fb_state_t ST_RUN      = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// rtl/vga_fb_reader_if.sv - read-side port of the single-port frame-buffer RAM
interface vga_fb_reader_if #(
  parameter int DEPTH_W = 15
);
  logic [DEPTH_W-1:0] addr;
  logic               en;
  logic               we;

  modport master (output addr, en, we);
  modport slave  (input addr, en, we);
endinterface

// File: rtl/vga_fb_addr_gen.sv
// rtl/vga_fb_addr_gen.sv - frame-buffer address generator: scaling counters, overflow flag and SOF/RUN FSM
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SCALE    = SCALE_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              sof_i,
  input  logic              de_i,
  vga_fb_reader_if.master   ram,
  output logic              ovf_o
);

  localparam int FB_W = H_ACTIVE / SCALE;
  localparam int FB_H = V_ACTIVE / SCALE;
  localparam int SW   = cnt_w(SCALE);
  localparam int XW   = cnt_w(FB_W);

  localparam logic [SW-1:0]      SUB_MAX   = SW'(SCALE - 1);
  localparam logic [XW-1:0]      COL_MAX   = XW'(FB_W - 1);
  localparam logic [DEPTH_W-1:0] LINE_STEP = DEPTH_W'(FB_W);
  localparam logic [DEPTH_W-1:0] BASE_MAX  = DEPTH_W'((FB_H - 1) * FB_W);

  fb_state_t          state_q, state_d;
  logic [SW-1:0]      x_sub_q, x_sub_d;
  logic [XW-1:0]      x_col_q, x_col_d;
  logic [SW-1:0]      y_sub_q, y_sub_d;
  logic [DEPTH_W-1:0] line_base_q, line_base_d;
  logic               x_end_q, x_end_d;
  logic               y_end_q, y_end_d;
  logic               ovf_q, ovf_d;
  logic               de_prev_q, de_prev_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic               ren_q, ren_d;

  logic run_en;
  logic sof_ok;
  logic active;

  assign run_en = (state_q == ST_RUN) && en_i;
  assign sof_ok = sof_i && en_i;
  assign active = run_en || sof_ok;

  always_comb begin
    state_d     = state_q;
    x_sub_d     = x_sub_q;
    x_col_d     = x_col_q;
    y_sub_d     = y_sub_q;
    line_base_d = line_base_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    ovf_d       = ovf_q;
    de_prev_d   = de_i;
    addr_d      = line_base_q + DEPTH_W'(x_col_q);
    ren_d       = 1'b0;

    if ((state_q == ST_RUN) && !en_i) begin
      state_d = ST_WAIT_SOF;
    end else if (sof_ok) begin
      state_d = ST_RUN;
    end

    // Frame start zeroes everything first so the SOF pixel itself reads address 0
    if (sof_i) begin
      x_sub_d     = '0;
      x_col_d     = '0;
      y_sub_d     = '0;
      line_base_d = '0;
      x_end_d     = 1'b0;
      y_end_d     = 1'b0;
      ovf_d       = 1'b0;
      addr_d      = '0;
    end

    if (active) begin
      ren_d = de_i;
      if (de_i) begin
        // x_end/y_end mark a saturated axis; a further pixel means the frame is oversized
        if (x_end_d || y_end_d) begin
          ovf_d = 1'b1;
        end
        if (x_sub_d == SUB_MAX) begin
          x_sub_d = '0;
          if (x_col_d == COL_MAX) begin
            x_end_d = 1'b1;
          end else begin
            x_col_d = x_col_d + 1'b1;
          end
        end else begin
          x_sub_d = x_sub_d + 1'b1;
        end
      end else if (de_prev_q && !sof_i) begin
        x_sub_d = '0;
        x_col_d = '0;
        x_end_d = 1'b0;
        if (y_sub_d == SUB_MAX) begin
          y_sub_d = '0;
          if (line_base_d == BASE_MAX) begin
            y_end_d = 1'b1;
          end else begin
            line_base_d = line_base_d + LINE_STEP;
          end
        end else begin
          y_sub_d = y_sub_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_WAIT_SOF;
      x_sub_q     <= '0;
      x_col_q     <= '0;
      y_sub_q     <= '0;
      line_base_q <= '0;
      x_end_q     <= 1'b0;
      y_end_q     <= 1'b0;
      ovf_q       <= 1'b0;
      de_prev_q   <= 1'b0;
      addr_q      <= '0;
      ren_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_sub_q     <= x_sub_d;
      x_col_q     <= x_col_d;
      y_sub_q     <= y_sub_d;
      line_base_q <= line_base_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      ovf_q       <= ovf_d;
      de_prev_q   <= de_prev_d;
      addr_q      <= addr_d;
      ren_q       <= ren_d;
    end
  end

  assign ram.addr = addr_q;
  assign ram.en   = ren_q;
  assign ram.we   = 1'b0;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - scaled frame-buffer to VGA reader: address stage plus colour/sync alignment stage
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SCALE    = SCALE_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               sof_i,
  input  logic               de_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  output logic [DEPTH_W-1:0] ram_addr_o,
  output logic               ram_en_o,
  output logic               ram_we_o,
  input  logic [RGB_W-1:0]   ram_data_i,
  output logic [CH_W-1:0]    red_o,
  output logic [CH_W-1:0]    green_o,
  output logic [CH_W-1:0]    blue_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic               ovf_o
);

  vga_fb_reader_if #(.DEPTH_W(DEPTH_W)) ram_if ();

  vga_fb_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .SCALE    (SCALE),
    .DEPTH_W  (DEPTH_W)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (en_i),
    .sof_i  (sof_i),
    .de_i   (de_i),
    .ram    (ram_if),
    .ovf_o  (ovf_o)
  );

  assign ram_addr_o = ram_if.addr;
  assign ram_en_o   = ram_if.en;
  assign ram_we_o   = ram_if.we;

  logic de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic de_s2_q, de_s2_d, hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
  logic rd_s2_q, rd_s2_d;
  logic show;

  always_comb begin
    de_s1_d = de_i;
    hs_s1_d = hsync_i;
    vs_s1_d = vsync_i;
    de_s2_d = de_s1_q;
    hs_s2_d = hs_s1_q;
    vs_s2_d = vs_s1_q;
    rd_s2_d = ram_if.en;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      de_s1_q <= 1'b0;
      hs_s1_q <= 1'b1;
      vs_s1_q <= 1'b1;
      de_s2_q <= 1'b0;
      hs_s2_q <= 1'b1;
      vs_s2_q <= 1'b1;
      rd_s2_q <= 1'b0;
    end else begin
      de_s1_q <= de_s1_d;
      hs_s1_q <= hs_s1_d;
      vs_s1_q <= vs_s1_d;
      de_s2_q <= de_s2_d;
      hs_s2_q <= hs_s2_d;
      vs_s2_q <= vs_s2_d;
      rd_s2_q <= rd_s2_d;
    end
  end

  // RAM data arrives in the cycle after the read, already aligned with the delayed syncs
  assign show    = rd_s2_q && de_s2_q;
  assign red_o   = show ? ram_data_i[3*CH_W-1:2*CH_W] : '0;
  assign green_o = show ? ram_data_i[2*CH_W-1:CH_W]   : '0;
  assign blue_o  = show ? ram_data_i[CH_W-1:0]        : '0;
  assign de_o    = de_s2_q;
  assign hsync_o = hs_s2_q;
  assign vsync_o = vs_s2_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - directed bench for vga_fb_reader with a per-cycle pixel scoreboard
module tb_vga_fb_reader;

  localparam int FBW = 160;

  logic        clk = 1'b0;
  logic        rstn_i, en_i, sof_i, de_i, hsync_i, vsync_i;
  logic [11:0] ram_data = 12'h000;
  logic [3:0]  red_o, green_o, blue_o;
  logic        hsync_o, vsync_o, de_o, ovf_o;

  vga_fb_reader_if #(.DEPTH_W(15)) fb_ram ();

  vga_fb_reader #(
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .SCALE    (4),
    .DEPTH_W  (15)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .sof_i      (sof_i),
    .de_i       (de_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .ram_addr_o (fb_ram.addr),
    .ram_en_o   (fb_ram.en),
    .ram_we_o   (fb_ram.we),
    .ram_data_i (ram_data),
    .red_o      (red_o),
    .green_o    (green_o),
    .blue_o     (blue_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .de_o       (de_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  // RAM preloaded with mem[a] = a[11:0]
  always @(posedge clk) begin
    if (fb_ram.en === 1'b1) ram_data <= fb_ram.addr[11:0];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  logic        cur_de = 1'b0, cur_hs = 1'b1, cur_vs = 1'b1, cur_rd = 1'b0;
  logic [14:0] cur_addr = '0;
  logic [11:0] cur_rgb = '0;

  logic        h_rd0 = 1'b0, h_de0 = 1'b0, h_de1 = 1'b0;
  logic        h_hs0 = 1'b1, h_hs1 = 1'b1, h_vs0 = 1'b1, h_vs1 = 1'b1;
  logic [14:0] h_addr0 = '0;
  logic [11:0] h_rgb0 = '0, h_rgb1 = '0;
  logic        mon_en = 1'b0;
  int          ren_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("ram_en", 32'(fb_ram.en), 32'(h_rd0));
      if (h_rd0) check("ram_addr", 32'(fb_ram.addr), 32'(h_addr0));
      check("de_o", 32'(de_o), 32'(h_de1));
      check("hsync_o", 32'(hsync_o), 32'(h_hs1));
      check("vsync_o", 32'(vsync_o), 32'(h_vs1));
      check("rgb", 32'({red_o, green_o, blue_o}), 32'(h_rgb1));
    end
    if (fb_ram.en === 1'b1) ren_cnt <= ren_cnt + 1;
    h_rd0 <= cur_rd;  h_addr0 <= cur_addr;
    h_de1 <= h_de0;   h_de0 <= cur_de;
    h_hs1 <= h_hs0;   h_hs0 <= cur_hs;
    h_vs1 <= h_vs0;   h_vs0 <= cur_vs;
    h_rgb1 <= h_rgb0; h_rgb0 <= cur_rgb;
  end

  task automatic drive(input logic d, input logic s, input logic h, input logic v,
                       input logic rd, input int x, input int y);
    int xc, yc;
    @(posedge clk);
    #1;
    de_i = d; sof_i = s; hsync_i = h; vsync_i = v;
    xc = x / 4; if (xc > FBW - 1) xc = FBW - 1;
    yc = y / 4; if (yc > 119) yc = 119;
    cur_de = d; cur_hs = h; cur_vs = v;
    cur_rd = rd & d;
    cur_addr = 15'(yc * FBW + xc);
    cur_rgb = cur_rd ? cur_addr[11:0] : 12'h000;
  endtask

  task automatic blank(input logic rd, input int y);
    drive(1'b0, 1'b0, 1'b1, 1'b1, rd, 0, y);
    drive(1'b0, 1'b0, 1'b0, 1'b1, rd, 0, y);
    drive(1'b0, 1'b0, 1'b0, 1'b1, rd, 0, y);
    drive(1'b0, 1'b0, 1'b1, 1'b1, rd, 0, y);
  endtask

  task automatic line(input int y, input int npix, input logic sof_first, input logic rd);
    for (int x = 0; x < npix; x++) drive(1'b1, sof_first && (x == 0), 1'b1, 1'b1, rd, x, y);
    blank(rd, y);
  endtask

  task automatic vblank();
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  int exp0 [5] = '{0, 0, 0, 0, 1};
  int snap;

  initial begin
    rstn_i = 1'b0; en_i = 1'b1; sof_i = 1'b0; de_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", 32'(fb_ram.en), 32'd0);
    check("rst_ram_addr", 32'(fb_ram.addr), 32'd0);
    check("rst_ram_we", 32'(fb_ram.we), 32'd0);
    check("rst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
    check("rst_de_o", 32'(de_o), 32'd0);
    check("rst_hsync_o", 32'(hsync_o), 32'd1);
    check("rst_vsync_o", 32'(vsync_o), 32'd1);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    @(posedge clk); #1 rstn_i = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    mon_en = 1'b1;

    // Frame A: ten full-width lines
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 640; x++) begin
        drive(1'b1, (y == 0) && (x == 0), 1'b1, 1'b1, 1'b1, x, y);
        if (y == 0 && x >= 1 && x <= 5) begin
          @(negedge clk);
          check("line0_addr", 32'(fb_ram.addr), 32'(exp0[x-1]));
        end
        if (y == 4 && x == 1) begin
          @(negedge clk);
          check("line4_addr", 32'(fb_ram.addr), 32'd160);
        end
        if (y == 9 && x == 7) begin
          @(negedge clk);
          check("px5_9_rgb", 32'({red_o, green_o, blue_o}), 32'h141);
          check("px5_9_de", 32'(de_o), 32'd1);
        end
      end
      blank(1'b1, y);
    end
    @(negedge clk);
    check("ovf_exact_width", 32'(ovf_o), 32'd0);
    vblank();

    // Frame B: 700-pixel line overflows horizontally
    for (int x = 0; x < 700; x++) begin
      drive(1'b1, x == 0, 1'b1, 1'b1, 1'b1, x, 0);
      if (x == 640) begin
        @(negedge clk);
        check("ovf_px639", 32'(ovf_o), 32'd0);
      end
      if (x == 641) begin
        @(negedge clk);
        check("ovf_px640", 32'(ovf_o), 32'd1);
      end
      if (x == 699) begin
        @(negedge clk);
        check("xcol_sat_addr", 32'(fb_ram.addr), 32'd159);
      end
    end
    blank(1'b1, 0);
    vblank();

    // Frame C: SOF clears the sticky overflow
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0);
    @(negedge clk);
    check("ovf_cleared", 32'(ovf_o), 32'd0);
    for (int x = 2; x < 8; x++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, x, 0);
    blank(1'b1, 0);
    en_i = 1'b0;

    // Disabled frame, then enabled without SOF: no reads at all
    snap = ren_cnt;
    vblank();
    line(0, 8, 1'b1, 1'b0);
    line(1, 8, 1'b0, 1'b0);
    line(2, 8, 1'b0, 1'b0);
    en_i = 1'b1;
    line(3, 8, 1'b0, 1'b0);
    check("no_read_en_low", 32'(ren_cnt - snap), 32'd0);
    vblank();

    // Frame D: 481 short lines overflow vertically
    line(0, 4, 1'b1, 1'b1);
    for (int y = 1; y < 480; y++) line(y, 4, 1'b0, 1'b1);
    @(negedge clk);
    check("ovf_line479", 32'(ovf_o), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 480);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 480);
    @(negedge clk);
    check("ovf_line480", 32'(ovf_o), 32'd1);
    for (int x = 2; x < 6; x++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, x, 480);

    // SOF arriving on the falling edge of the stale line
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    @(negedge clk);
    check("sof_fall_addr", 32'(fb_ram.addr), 32'd0);
    check("sof_fall_ovf", 32'(ovf_o), 32'd0);
    for (int x = 1; x < 4; x++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, x, 0);
    blank(1'b1, 0);
    for (int y = 1; y < 200; y++) line(y, 4, 1'b0, 1'b1);

    // Reset in the middle of line 200
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 200);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 200);
    @(negedge clk);
    check("line200_addr", 32'(fb_ram.addr), 32'd8000);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 200);
    mon_en = 1'b0;
    #2 rstn_i = 1'b0;
    snap = ren_cnt;
    #1;
    check("midrst_ram_en", 32'(fb_ram.en), 32'd0);
    check("midrst_ram_addr", 32'(fb_ram.addr), 32'd0);
    check("midrst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
    check("midrst_de_o", 32'(de_o), 32'd0);
    check("midrst_hsync_o", 32'(hsync_o), 32'd1);
    check("midrst_vsync_o", 32'(vsync_o), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 200);
    rstn_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 200);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 200);
    mon_en = 1'b1;
    line(201, 4, 1'b0, 1'b0);
    line(202, 4, 1'b0, 1'b0);
    check("no_read_after_rst", 32'(ren_cnt - snap), 32'd0);
    vblank();

    // Frame F: first read after reset starts at address 0
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0);
    @(negedge clk);
    check("post_rst_addr", 32'(fb_ram.addr), 32'd0);
    check("post_rst_ren", 32'(fb_ram.en), 32'd1);
    for (int x = 2; x < 8; x++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, x, 0);
    blank(1'b1, 0);
    vblank();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
